// File: rtl/gf2m_inv_seq_pkg.sv
// Shared constants for the GF(2^163) Itoh-Tsujii inversion sequencer:
// field width, field one, addition-chain table and FSM state encodings.
package gf2m_inv_seq_pkg;

    localparam int GF_M = 163;
    localparam logic [GF_M-1:0] FIELD_ONE = {162'b0, 1'b1};

    // Addition-chain step kinds
    localparam logic STEP_DBL = 1'b0;   // k -> 2k
    localparam logic STEP_P1  = 1'b1;   // k -> k+1

    // Chain 1->2->4->5->10->20->40->80->81->162 has nine transitions,
    // so the table holds indices 0..8.
    localparam logic [3:0] LAST_STEP = 4'd8;

    // FSM state encodings
    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_LOAD     = 4'd1;
    localparam logic [3:0] S_SQ       = 4'd2;
    localparam logic [3:0] S_WAIT_SQ  = 4'd3;
    localparam logic [3:0] S_MUL      = 4'd4;
    localparam logic [3:0] S_WAIT_MUL = 4'd5;
    localparam logic [3:0] S_FIN      = 4'd6;
    localparam logic [3:0] S_WAIT_FIN = 4'd7;
    localparam logic [3:0] S_DONE     = 4'd8;

    // Chain ROM: step type per chain index (4->5 and 80->81 are plus-one)
    function automatic logic chain_type(input logic [3:0] step);
        logic t;
        case (step)
            4'd2, 4'd7: t = STEP_P1;
            default:    t = STEP_DBL;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/gf2m_inv_seq.sv
// Itoh-Tsujii inversion sequencer for GF(2^163): drives one acb unit through
// 162 squarings and 9 multiplies to produce a^(2^163-2) = a^-1.
module gf2m_inv_seq
    import gf2m_inv_seq_pkg::*;
#(
    parameter int M           = GF_M,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [M-1:0] a_in,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [M-1:0] inv_out,
    output logic         acb_enable,
    output logic         acb_configuration,
    output logic [M-1:0] acb_A,
    output logic [M-1:0] acb_B,
    input  logic [M-1:0] acb_C,
    input  logic         acb_done
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

    logic [3:0]    state_q,  state_d;
    logic [M-1:0]  a_r_q,    a_r_d;
    logic [M-1:0]  beta_q,   beta_d;
    logic [M-1:0]  t_r_q,    t_r_d;
    logic [7:0]    k_q,      k_d;
    logic [7:0]    sq_cnt_q, sq_cnt_d;
    logic [3:0]    step_q,   step_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic [M-1:0]  inv_q,    inv_d;
    logic          err_q,    err_d;
    logic          en_q,     en_d;
    logic          cfg_q,    cfg_d;
    logic [M-1:0]  op_a_q,   op_a_d;
    logic [M-1:0]  op_b_q,   op_b_d;
    logic          is_dbl;
    logic          wait_idle;

    assign is_dbl = (chain_type(step_q) == STEP_DBL);

    // Next-state and datapath: operands are loaded on the transition into an
    // issue state, and the enable flop fires from that state, so A/B/config
    // are already stable for one cycle when acb_enable rises.
    always_comb begin
        state_d   = state_q;
        a_r_d     = a_r_q;
        beta_d    = beta_q;
        t_r_d     = t_r_q;
        k_d       = k_q;
        sq_cnt_d  = sq_cnt_q;
        step_d    = step_q;
        to_cnt_d  = to_cnt_q;
        inv_d     = inv_q;
        err_d     = 1'b0;
        en_d      = 1'b0;
        cfg_d     = cfg_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        wait_idle = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_r_d   = a_in;
                    beta_d  = a_in;
                    k_d     = 8'd1;
                    step_d  = '0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (is_dbl) begin
                    t_r_d    = beta_q;
                    sq_cnt_d = k_q;
                end else begin
                    sq_cnt_d = 8'd1;
                end
                op_a_d  = beta_q;
                op_b_d  = FIELD_ONE;
                cfg_d   = 1'b0;
                state_d = S_SQ;
            end
            S_SQ: begin
                en_d     = 1'b1;
                to_cnt_d = '0;
                state_d  = S_WAIT_SQ;
            end
            S_WAIT_SQ: begin
                if (acb_done) begin
                    beta_d   = acb_C;
                    sq_cnt_d = sq_cnt_q - 8'd1;
                    op_a_d   = acb_C;
                    if (sq_cnt_q == 8'd1) begin
                        op_b_d  = is_dbl ? t_r_q : a_r_q;
                        cfg_d   = 1'b1;
                        state_d = S_MUL;
                    end else begin
                        op_b_d  = FIELD_ONE;
                        cfg_d   = 1'b0;
                        state_d = S_SQ;
                    end
                end else begin
                    wait_idle = 1'b1;
                end
            end
            S_MUL: begin
                en_d     = 1'b1;
                to_cnt_d = '0;
                state_d  = S_WAIT_MUL;
            end
            S_WAIT_MUL: begin
                if (acb_done) begin
                    beta_d = acb_C;
                    if (step_q == LAST_STEP) begin
                        op_a_d  = acb_C;
                        op_b_d  = FIELD_ONE;
                        cfg_d   = 1'b0;
                        state_d = S_FIN;
                    end else begin
                        step_d  = step_q + 4'd1;
                        k_d     = is_dbl ? (k_q << 1) : (k_q + 8'd1);
                        state_d = S_LOAD;
                    end
                end else begin
                    wait_idle = 1'b1;
                end
            end
            S_FIN: begin
                en_d     = 1'b1;
                to_cnt_d = '0;
                state_d  = S_WAIT_FIN;
            end
            S_WAIT_FIN: begin
                if (acb_done) begin
                    inv_d   = acb_C;
                    state_d = S_DONE;
                end else begin
                    wait_idle = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Shared timeout for all WAIT states
        if (wait_idle) begin
            if (to_cnt_q == TO_LAST) begin
                err_d   = 1'b1;
                state_d = S_IDLE;
            end else begin
                to_cnt_d = to_cnt_q + 1'b1;
            end
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_r_q    <= '0;
            beta_q   <= '0;
            t_r_q    <= '0;
            k_q      <= '0;
            sq_cnt_q <= '0;
            step_q   <= '0;
            to_cnt_q <= '0;
            inv_q    <= '0;
            err_q    <= 1'b0;
            en_q     <= 1'b0;
            cfg_q    <= 1'b0;
            op_a_q   <= '0;
            op_b_q   <= '0;
        end else begin
            state_q  <= state_d;
            a_r_q    <= a_r_d;
            beta_q   <= beta_d;
            t_r_q    <= t_r_d;
            k_q      <= k_d;
            sq_cnt_q <= sq_cnt_d;
            step_q   <= step_d;
            to_cnt_q <= to_cnt_d;
            inv_q    <= inv_d;
            err_q    <= err_d;
            en_q     <= en_d;
            cfg_q    <= cfg_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
        end
    end

    assign busy              = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done              = (state_q == S_DONE);
    assign err               = err_q;
    assign inv_out           = inv_q;
    assign acb_enable        = en_q;
    assign acb_configuration = cfg_q;
    assign acb_A             = op_a_q;
    assign acb_B             = op_b_q;

endmodule

// File: tb/tb_gf2m_inv_seq.sv
// Bench for gf2m_inv_seq: behavioural acb with random done latency, a
// scoreboard queue filled at issue time and a monitor that checks each
// done/err pulse against it.
module tb_gf2m_inv_seq;

    localparam int M  = 163;
    localparam int TO = 1024;
    localparam logic [M-1:0] POLY_LOW = 163'hC9;
    localparam logic [M-1:0] ONE      = 163'h1;
    localparam logic [M-1:0] X_INV    = 163'h4_0000_0000_0000_0000_0000_0000_0000_0000_0000_0064;

    logic         clk, rst, start;
    logic [M-1:0] a_in;
    logic         busy, done, err;
    logic [M-1:0] inv_out;
    logic         acb_enable, acb_configuration;
    logic [M-1:0] acb_A, acb_B, acb_C;
    logic         acb_done;

    gf2m_inv_seq #(.M(M), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .a_in(a_in),
        .busy(busy), .done(done), .err(err), .inv_out(inv_out),
        .acb_enable(acb_enable), .acb_configuration(acb_configuration),
        .acb_A(acb_A), .acb_B(acb_B), .acb_C(acb_C), .acb_done(acb_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic         is_err;
        logic         chk_prod;
        logic [M-1:0] a;
        logic [M-1:0] exp;
    } sb_t;
    sb_t sbq[$];

    int total = 0, bad = 0;
    int done_cnt = 0, err_cnt = 0;
    int en_cnt = 0, last_en_cyc = 0;
    int hold_at = -1;
    int lat_hi = 6;

    function automatic logic [M-1:0] gf_mul(input logic [M-1:0] x, input logic [M-1:0] y);
        logic [M-1:0] r, b;
        r = '0;
        b = x;
        for (int i = 0; i < M; i++) begin
            if (y[i]) r = r ^ b;
            b = {b[M-2:0], 1'b0} ^ (b[M-1] ? POLY_LOW : '0);
        end
        return r;
    endfunction

    // Fermat inverse: product of a^(2^i) for i=1..162
    function automatic logic [M-1:0] gf_inv(input logic [M-1:0] a);
        logic [M-1:0] r, s;
        r = ONE;
        s = a;
        for (int i = 1; i < M; i++) begin
            s = gf_mul(s, s);
            r = gf_mul(r, s);
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [M-1:0] got, input logic [M-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", name, got, exp);
        end
    endtask

    // Behavioural acb: one op at a time, result after 3..lat_hi cycles
    initial begin
        logic [M-1:0] res;
        int cnt;
        logic pend;
        acb_done = 1'b0;
        acb_C    = '0;
        pend     = 1'b0;
        cnt      = 0;
        forever begin
            @(posedge clk);
            #1;
            acb_done = 1'b0;
            if (rst) begin
                pend = 1'b0;
            end else begin
                if (pend) begin
                    cnt--;
                    if (cnt == 0) begin
                        acb_done = 1'b1;
                        acb_C    = res;
                        pend     = 1'b0;
                    end
                end
                if (acb_enable) begin
                    en_cnt++;
                    last_en_cyc = cyc;
                    res = gf_mul(acb_A, acb_B);
                    if (!acb_configuration) res = gf_mul(res, res);
                    if (en_cnt != hold_at) begin
                        pend = 1'b1;
                        cnt  = $urandom_range(3, lat_hi);
                    end
                end
            end
        end
    end

    // Monitor: every done/err pulse is matched against the scoreboard
    initial begin
        sb_t e;
        forever begin
            @(negedge clk);
            if (done || err) begin
                if (done) done_cnt++;
                if (err) err_cnt++;
                chk("busy_at_end", M'(busy), '0);
                if (sbq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_end: done=%0b err=%0b expected=none", done, err);
                end else begin
                    e = sbq.pop_front();
                    chk("end_kind_err", M'(err), M'(e.is_err));
                    if (e.is_err) begin
                        chk("timeout_latency", M'(cyc - last_en_cyc), M'(TO));
                    end else begin
                        chk("inv_out", inv_out, e.exp);
                        if (e.chk_prod) chk("a_times_inv", gf_mul(e.a, inv_out), ONE);
                    end
                end
            end
        end
    end

    task automatic push(input logic is_err, input logic chk_prod, input logic [M-1:0] a,
                        input logic [M-1:0] exp);
        sb_t e;
        e.is_err   = is_err;
        e.chk_prod = chk_prod;
        e.a        = a;
        e.exp      = exp;
        sbq.push_back(e);
    endtask

    task automatic issue(input logic [M-1:0] a);
        @(negedge clk);
        a_in  = a;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end(input string name, input int limit);
        int base;
        bit seen;
        base = done_cnt + err_cnt;
        seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(posedge clk);
            if (done_cnt + err_cnt != base) seen = 1'b1;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL %s_timeout: no done/err within %0d cycles", name, limit);
        end
    endtask

    function automatic logic [M-1:0] rand_elem();
        logic [191:0] rw;
        rw = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return rw[M-1:0];
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, M'(busy), '0);
        chk({tag, "_done"}, M'(done), '0);
        chk({tag, "_err"}, M'(err), '0);
        chk({tag, "_inv_out"}, inv_out, '0);
        chk({tag, "_acb_enable"}, M'(acb_enable), '0);
        chk({tag, "_acb_cfg"}, M'(acb_configuration), '0);
        chk({tag, "_acb_A"}, acb_A, '0);
        chk({tag, "_acb_B"}, acb_B, '0);
    endtask

    initial begin
        logic [M-1:0] a, a1;
        int base_en, base_done, base_err, lim;
        bit seen;

        rst   = 1'b1;
        start = 1'b0;
        a_in  = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_all_zero("reset");

        lim = 171 * (lat_hi + 4) + 50;

        // a=1: inverse 1, exactly 171 acb ops
        base_en = en_cnt;
        push(1'b0, 1'b1, ONE, ONE);
        issue(ONE);
        wait_end("one", lim);
        chk("enable_count_one", M'(en_cnt - base_en), M'(171));

        // a=x and a=x^-1
        push(1'b0, 1'b1, 163'h2, X_INV);
        issue(163'h2);
        wait_end("x", lim);
        push(1'b0, 1'b1, X_INV, 163'h2);
        issue(X_INV);
        wait_end("x_inv", lim);

        // a=0 runs the full chain and yields 0
        base_en = en_cnt;
        push(1'b0, 1'b0, '0, '0);
        issue('0);
        wait_end("zero", lim);
        chk("enable_count_zero", M'(en_cnt - base_en), M'(171));

        // random operands with longer latency
        lat_hi = 40;
        lim = 171 * (lat_hi + 4) + 50;
        for (int n = 0; n < 6; n++) begin
            a = rand_elem();
            if (a == '0) a = 163'h3;
            push(1'b0, 1'b1, a, gf_inv(a));
            issue(a);
            wait_end("random", lim);
        end
        lat_hi = 6;
        lim = 171 * (lat_hi + 4) + 50;

        // start held high while busy and through the done cycle
        base_done = done_cnt;
        a1 = rand_elem();
        if (a1 == '0) a1 = 163'h5;
        push(1'b0, 1'b1, a1, gf_inv(a1));
        @(negedge clk);
        a_in  = a1;
        start = 1'b1;
        seen  = 1'b0;
        for (int i = 0; i < lim && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
            else a_in = rand_elem();
        end
        a_in = rand_elem();
        @(negedge clk);
        start = 1'b0;
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL busy_start_timeout: no done within %0d cycles", lim);
        end
        repeat (5) @(negedge clk);
        chk("busy_start_single_done", M'(done_cnt - base_done), M'(1));
        chk("busy_start_idle_after", M'(busy), '0);

        // reset in the middle of an inversion
        base_en   = en_cnt;
        base_done = done_cnt;
        base_err  = err_cnt;
        issue(rand_elem());
        seen = 1'b0;
        for (int i = 0; i < lim && !seen; i++) begin
            @(negedge clk);
            if (en_cnt - base_en >= 50) seen = 1'b1;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL midrst_reach_op50: enables=%0d required=50", en_cnt - base_en);
        end
        rst = 1'b1;
        @(negedge clk);
        chk_all_zero("midrst");
        rst = 1'b0;
        repeat (250) @(negedge clk);
        chk("midrst_no_done", M'(done_cnt - base_done), '0);
        chk("midrst_no_err", M'(err_cnt - base_err), '0);
        a = rand_elem();
        if (a == '0) a = 163'h7;
        push(1'b0, 1'b1, a, gf_inv(a));
        issue(a);
        wait_end("after_rst", lim);

        // acb never answers the 10th op of this inversion
        base_done = done_cnt;
        hold_at   = en_cnt + 10;
        push(1'b1, 1'b0, '0, '0);
        issue(rand_elem());
        wait_end("timeout", lim + TO);
        hold_at = -1;
        repeat (3) @(negedge clk);
        chk("timeout_no_done", M'(done_cnt - base_done), '0);
        chk("timeout_busy_low", M'(busy), '0);

        // recovery after timeout
        push(1'b0, 1'b1, X_INV, 163'h2);
        issue(X_INV);
        wait_end("recover", lim);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", M'(sbq.size()), '0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
